// File: rtl/db_copy_engine_pkg.sv
// Shared data-bus encodings for the copy engine and its bus interface.
// Mirrors the access/length codes the CPU_MMU uses on the same bus.
package db_copy_engine_pkg;

    localparam int DB_ADDR_W = 32;
    localparam int DB_DATA_W = 32;

    typedef enum logic [1:0] {
        MEM_ACCESS_NONE = 2'd0,
        MEM_ACCESS_R    = 2'd1,
        MEM_ACCESS_W    = 2'd2,
        MEM_ACCESS_X    = 2'd3
    } MEM_ACCESS_T;

    typedef enum logic [1:0] {
        MEM_LEN_B = 2'd0,
        MEM_LEN_H = 2'd1,
        MEM_LEN_W = 2'd2
    } MEM_LEN;

    // Number of bytes moved by one access of the given size.
    function automatic logic [2:0] len_bytes(input MEM_LEN l);
        case (l)
            MEM_LEN_W: return 3'd4;
            MEM_LEN_H: return 3'd2;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/db_copy_engine_if.sv
// Data-bus request/response bundle; the engine is a master, memory/IO a slave.
interface db_copy_engine_if;
    import db_copy_engine_pkg::*;

    logic [DB_ADDR_W-1:0] db_addr;
    logic [DB_DATA_W-1:0] db_dataOut;
    logic [DB_DATA_W-1:0] db_dataIn;
    MEM_ACCESS_T          db_accessType;
    MEM_LEN               db_memLen;
    logic                 db_io;
    logic                 db_ready;

    modport master (
        output db_addr, db_dataOut, db_accessType, db_memLen, db_io,
        input  db_dataIn, db_ready
    );

    modport slave (
        input  db_addr, db_dataOut, db_accessType, db_memLen, db_io,
        output db_dataIn, db_ready
    );

endinterface

// File: rtl/db_copy_engine.sv
// Second data-bus master: copies a byte block with paired read/write transactions,
// using word accesses when both ends are aligned, or streams bytes to a fixed IO port.
module db_copy_engine
    import db_copy_engine_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [31:0]       src,
    input  logic [31:0]       dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              dst_io,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  xfer_cnt,
    db_copy_engine_if.master  db
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_LATCH = 3'd2,
        ST_WR    = 3'd3,
        ST_DONE  = 3'd4
    } copy_state_t;

    copy_state_t      state;
    logic [31:0]      cur_src;
    logic [31:0]      cur_dst;
    logic [LEN_W-1:0] rem;
    logic             io_q;

    logic [2:0]       step;
    logic [31:0]      nxt_src;
    logic [31:0]      nxt_dst;
    logic [LEN_W-1:0] nxt_rem;

    // Word only when both ends are aligned, enough bytes remain and memory is the target.
    function automatic MEM_LEN pick_size(input logic [31:0] s, input logic [31:0] d,
                                         input logic [LEN_W-1:0] r, input logic io);
        if (s[1:0] == 2'b00 && d[1:0] == 2'b00 && r >= LEN_W'(4) && !io)
            return MEM_LEN_W;
        return MEM_LEN_B;
    endfunction

    // The registered bus size stays fixed across RD/LATCH/WR, so it sets the stride.
    always_comb begin
        step    = len_bytes(db.db_memLen);
        nxt_src = cur_src + 32'(step);
        nxt_dst = io_q ? cur_dst : cur_dst + 32'(step);
        nxt_rem = rem - LEN_W'(step);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state            <= ST_IDLE;
            cur_src          <= '0;
            cur_dst          <= '0;
            rem              <= '0;
            io_q             <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            xfer_cnt         <= '0;
            db.db_addr       <= '0;
            db.db_dataOut    <= '0;
            db.db_accessType <= MEM_ACCESS_NONE;
            db.db_memLen     <= MEM_LEN_B;
            db.db_io         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    db.db_accessType <= MEM_ACCESS_NONE;
                    if (start) begin
                        cur_src  <= src;
                        cur_dst  <= dst;
                        rem      <= len;
                        io_q     <= dst_io;
                        xfer_cnt <= '0;
                        if (len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state            <= ST_RD;
                            busy             <= 1'b1;
                            db.db_addr       <= src;
                            db.db_accessType <= MEM_ACCESS_R;
                            db.db_memLen     <= pick_size(src, dst, len, dst_io);
                            db.db_io         <= 1'b0;
                        end
                    end
                end

                ST_RD: begin
                    if (abort) begin
                        state            <= ST_IDLE;
                        busy             <= 1'b0;
                        db.db_accessType <= MEM_ACCESS_NONE;
                    end else if (db.db_ready) begin
                        state            <= ST_LATCH;
                        db.db_accessType <= MEM_ACCESS_NONE;
                    end
                end

                // Read data is registered by the responder, so it is valid here.
                ST_LATCH: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state            <= ST_WR;
                        db.db_dataOut    <= db.db_dataIn;
                        db.db_addr       <= cur_dst;
                        db.db_accessType <= MEM_ACCESS_W;
                        db.db_io         <= io_q;
                    end
                end

                // A write accepted on the same edge as abort is committed and counted.
                ST_WR: begin
                    if (db.db_ready) begin
                        cur_src  <= nxt_src;
                        cur_dst  <= nxt_dst;
                        rem      <= nxt_rem;
                        xfer_cnt <= xfer_cnt + LEN_W'(step);
                        if (abort) begin
                            state            <= ST_IDLE;
                            busy             <= 1'b0;
                            db.db_accessType <= MEM_ACCESS_NONE;
                        end else if (nxt_rem == '0) begin
                            state            <= ST_DONE;
                            busy             <= 1'b0;
                            done             <= 1'b1;
                            db.db_accessType <= MEM_ACCESS_NONE;
                        end else begin
                            state            <= ST_RD;
                            db.db_addr       <= nxt_src;
                            db.db_accessType <= MEM_ACCESS_R;
                            db.db_memLen     <= pick_size(nxt_src, nxt_dst, nxt_rem, io_q);
                            db.db_io         <= 1'b0;
                        end
                    end else if (abort) begin
                        state            <= ST_IDLE;
                        busy             <= 1'b0;
                        db.db_accessType <= MEM_ACCESS_NONE;
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state            <= ST_IDLE;
                    busy             <= 1'b0;
                    db.db_accessType <= MEM_ACCESS_NONE;
                end
            endcase
        end
    end

endmodule
